// File: rtl/usr_defs.sv
// usr_defs: mode encodings shared by the universal shift register and its bench
package usr_defs;
  localparam logic [2:0] HOLD  = 3'b000;
  localparam logic [2:0] SHR   = 3'b001;
  localparam logic [2:0] SHL   = 3'b010;
  localparam logic [2:0] LOAD  = 3'b011;
  localparam logic [2:0] RINGR = 3'b100;
  localparam logic [2:0] JOHNR = 3'b101;
  localparam logic [2:0] RINGL = 3'b110;
  localparam logic [2:0] RSVD  = 3'b111;
endpackage

// File: rtl/d_ff_sr.sv
// d_ff_sr: positive-edge DFF with synchronous active-high clear and enable
module d_ff_sr (
  input  logic CP,
  input  logic CR,
  input  logic EN,
  input  logic D,
  output logic Q,
  output logic QR
);
  always_ff @(posedge CP)
    if (CR) Q <= 1'b0;
    else if (EN) Q <= D;
  assign QR = ~Q;
endmodule

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: shift/load/ring/Johnson register built from per-bit d_ff_sr cells
module universal_shift_reg
  import usr_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             EN,
  input  logic [2:0]       S,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QR,
  output logic             SOR,
  output logic             SOL
);
  logic             w_rin;
  logic             w_lin;
  logic             w_rdir;
  logic             w_ldir;
  logic [WIDTH-1:0] w_next;
  always_comb begin
    w_rin  = (S == RINGR) ? Q[0] : (S == JOHNR) ? ~Q[0] : DSR;
    w_lin  = (S == RINGL) ? Q[WIDTH-1] : DSL;
    w_rdir = (S == SHR) || (S == RINGR) || (S == JOHNR);
    w_ldir = (S == SHL) || (S == RINGL);
    w_next = w_rdir ? {w_rin, Q[WIDTH-1:1]} :
             w_ldir ? {Q[WIDTH-2:0], w_lin} :
             (S == LOAD) ? D : Q;
  end
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    d_ff_sr u_ff (
      .CP(CP),
      .CR(CR),
      .EN(EN),
      .D (w_next[g]),
      .Q (Q[g]),
      .QR(QR[g])
    );
  end
  assign SOR = Q[0];
  assign SOL = Q[WIDTH-1];
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed vector table plus randomized run against an arithmetic model
module tb_universal_shift_reg;
  import usr_defs::*;
  localparam int W = 4;
  typedef struct {
    logic         cr;
    logic         en;
    logic [2:0]   s;
    logic         dsr;
    logic         dsl;
    logic [W-1:0] d;
    logic [W-1:0] q;
  } vec_t;
  logic CP = 1'b0;
  logic CR = 1'b0;
  logic EN = 1'b0;
  logic [2:0] S = HOLD;
  logic DSR = 1'b0;
  logic DSL = 1'b0;
  logic [W-1:0] D = '0;
  logic [W-1:0] Q;
  logic [W-1:0] QR;
  logic SOR;
  logic SOL;
  int vectors = 0;
  int miscompares = 0;
  vec_t tbl[$];
  logic [W-1:0] mq;
  universal_shift_reg #(.WIDTH(W)) dut (
    .CP(CP), .CR(CR), .EN(EN), .S(S), .DSR(DSR), .DSL(DSL), .D(D),
    .Q(Q), .QR(QR), .SOR(SOR), .SOL(SOL)
  );
  always #5 CP = ~CP;
  task automatic add(input logic cr, input logic en, input logic [2:0] s,
                     input logic dsr, input logic dsl, input logic [W-1:0] d, input logic [W-1:0] q);
    vec_t v;
    v.cr = cr; v.en = en; v.s = s; v.dsr = dsr; v.dsl = dsl; v.d = d; v.q = q;
    tbl.push_back(v);
  endtask
  function automatic logic [W-1:0] model(input logic [W-1:0] q, input logic cr, input logic en,
                                         input logic [2:0] s, input logic dsr, input logic dsl,
                                         input logic [W-1:0] d);
    int v, top, lsb, msb;
    v = int'(q);
    top = 1 << (W - 1);
    lsb = v % 2;
    msb = v / top;
    if (cr) return '0;
    if (!en) return q;
    case (s)
      SHR:     v = v / 2 + int'(dsr) * top;
      SHL:     v = (v * 2 + int'(dsl)) % (1 << W);
      LOAD:    v = int'(d);
      RINGR:   v = v / 2 + lsb * top;
      JOHNR:   v = v / 2 + (1 - lsb) * top;
      RINGL:   v = (v * 2 + msb) % (1 << W);
      default: v = v;
    endcase
    return W'(v);
  endfunction
  task automatic apply(input vec_t v, input string name);
    CR = v.cr; EN = v.en; S = v.s; DSR = v.dsr; DSL = v.dsl; D = v.d;
    @(posedge CP);
    #1;
    vectors++;
    if (Q !== v.q || QR !== ~v.q || SOR !== v.q[0] || SOL !== v.q[W-1]) begin
      miscompares++;
      $display("FAIL %s #%0d: Q=%b QR=%b SOR=%b SOL=%b, required Q=%b QR=%b SOR=%b SOL=%b",
               name, vectors, Q, QR, SOR, SOL, v.q, ~v.q, v.q[0], v.q[W-1]);
    end
  endtask
  initial begin
    add(1, 1, LOAD, 0, 0, 4'b1010, 4'b0000);
    add(1, 1, LOAD, 0, 0, 4'b1010, 4'b0000);
    add(0, 1, LOAD, 0, 0, 4'b1011, 4'b1011);
    add(0, 1, SHR,  0, 0, 4'b1111, 4'b0101);
    add(0, 1, SHR,  0, 0, 4'b1111, 4'b0010);
    add(0, 1, SHR,  0, 0, 4'b1111, 4'b0001);
    add(0, 1, SHR,  1, 0, 4'b0000, 4'b1000);
    add(0, 1, LOAD, 0, 0, 4'b0001, 4'b0001);
    add(0, 1, RINGL, 1, 0, 4'b1111, 4'b0010);
    add(0, 1, RINGL, 1, 0, 4'b1111, 4'b0100);
    add(0, 1, RINGL, 1, 0, 4'b1111, 4'b1000);
    add(0, 1, RINGL, 1, 0, 4'b1111, 4'b0001);
    add(1, 0, HOLD, 0, 0, 4'b0000, 4'b0000);
    add(0, 1, JOHNR, 0, 0, 4'b0000, 4'b1000);
    add(0, 1, JOHNR, 0, 0, 4'b0000, 4'b1100);
    add(0, 1, JOHNR, 0, 0, 4'b0000, 4'b1110);
    add(0, 1, JOHNR, 0, 0, 4'b0000, 4'b1111);
    add(0, 1, JOHNR, 0, 0, 4'b0000, 4'b0111);
    add(0, 1, JOHNR, 0, 0, 4'b0000, 4'b0011);
    add(0, 1, JOHNR, 0, 0, 4'b0000, 4'b0001);
    add(0, 1, JOHNR, 0, 0, 4'b0000, 4'b0000);
    add(0, 1, LOAD, 0, 0, 4'b1011, 4'b1011);
    add(0, 0, SHR,  1, 1, 4'b0000, 4'b1011);
    add(0, 0, SHR,  1, 1, 4'b0000, 4'b1011);
    add(0, 0, SHR,  1, 1, 4'b0000, 4'b1011);
    add(1, 0, SHR,  1, 1, 4'b0000, 4'b0000);
    add(0, 1, JOHNR, 0, 0, 4'b0000, 4'b1000);
    add(0, 1, JOHNR, 0, 0, 4'b0000, 4'b1100);
    add(0, 1, JOHNR, 0, 0, 4'b0000, 4'b1110);
    add(1, 1, JOHNR, 0, 0, 4'b0000, 4'b0000);
    add(0, 1, SHL,  0, 1, 4'b0000, 4'b0001);
    add(0, 1, SHL,  0, 1, 4'b0000, 4'b0011);
    add(0, 1, LOAD, 0, 0, 4'b0110, 4'b0110);
    add(0, 1, RSVD, 1, 1, 4'b1001, 4'b0110);
    add(0, 1, HOLD, 1, 1, 4'b1001, 4'b0110);
    add(0, 1, RINGR, 1, 1, 4'b1111, 4'b0011);
    add(0, 1, RINGR, 1, 1, 4'b1111, 4'b1001);
    add(0, 1, RINGR, 0, 0, 4'b0000, 4'b1100);
    add(1, 1, RINGR, 0, 0, 4'b0000, 4'b0000);
    add(0, 1, RINGR, 1, 1, 4'b1111, 4'b0000);
    add(0, 1, RINGL, 1, 1, 4'b1111, 4'b0000);
    foreach (tbl[i]) begin
      apply(tbl[i], "table");
      mq = tbl[i].q;
    end
    for (int k = 0; k < 400; k++) begin
      vec_t v;
      v.cr  = ($urandom_range(15) == 0);
      v.en  = ($urandom_range(3) != 0);
      v.s   = 3'($urandom_range(7));
      v.dsr = 1'($urandom);
      v.dsl = 1'($urandom);
      v.d   = W'($urandom);
      mq    = model(mq, v.cr, v.en, v.s, v.dsr, v.dsl, v.d);
      v.q   = mq;
      apply(v, "random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits; legal range 2..16.
REQ-002 CP  input  1  clock; all state changes on rising edge of CP only.
REQ-003 CR  input  1  reset; synchronous, active-high, sampled on rising edge of CP.
REQ-004 EN  input  1  clock enable; 0 = hold all state.
REQ-005 S   input  3  mode select, encoding per REQ-012.
REQ-006 DSR  input  1  serial data in, right-shift direction.
REQ-007 DSL  input  1  serial data in, left-shift direction.
REQ-008 D   input  WIDTH  parallel load data.
REQ-009 Q   output  WIDTH  register state.
REQ-010 QR  output  WIDTH  bitwise complement of Q, same cycle.
REQ-011 SOR, SOL  output  1 each  serial outs: SOR = Q[0], SOL = Q[WIDTH-1]; combinational from Q.

Function
REQ-012 Mode on rising edge of CP with CR=0, EN=1:
- 000 hold: Q unchanged.
- 001 shift right: Q[WIDTH-1] <= DSR; Q[i] <= Q[i+1].
- 010 shift left: Q[0] <= DSL; Q[i] <= Q[i-1].
- 011 parallel load: Q <= D.
- 100 ring right: Q[WIDTH-1] <= Q[0]; rest as shift right.
- 101 Johnson right: Q[WIDTH-1] <= ~Q[0]; rest as shift right.
- 110 ring left: Q[0] <= Q[WIDTH-1]; rest as shift left.
- 111 reserved: behaves as hold.
REQ-013 Latency: a mode's effect is visible on Q one CP edge after sampling; no input-to-Q combinational path.
REQ-014 Priority: CR > EN > S.
REQ-015 EN=0 holds Q for any S, DSR, DSL, D.
REQ-016 A mode change between consecutive edges takes effect on the next edge; no residual state carries across modes.
REQ-017 Ring modes preserve the population count of Q; from 0000 they remain 0000.
REQ-018 Johnson mode from 0 cycles with period 2*WIDTH. No illegal-state correction is performed.
REQ-019 QR, SOR and SOL track Q with no extra register stage.
REQ-020 No X on any output once the first reset edge has completed.

Reset
REQ-021 On a CP rising edge with CR=1: Q = 0, QR = all ones, SOR = 0, SOL = 0, regardless of EN and S.
REQ-022 CR asserted mid-shift or mid-Johnson cycle clears Q on that edge; the next edge after CR deasserts resumes from 0 in the selected mode.
REQ-023 Before the first reset edge, Q is undefined; the bench does not check outputs before that edge.

Structure
REQ-024 The mode encodings (HOLD, SHR, SHL, LOAD, RINGR, JOHNR, RINGL, RSVD) are defined as named 3-bit constants in the shared package/include usr_defs and are used by both RTL and bench.
REQ-025 Per-bit storage uses one sub-module d_ff_sr: a positive-edge DFF with synchronous active-high clear and enable, ports CP, CR, EN, D, Q, QR; the block instantiates WIDTH copies.
REQ-026 Next-state selection is a per-bit combinational mux in universal_shift_reg; d_ff_sr contains no mode logic.

Verification (WIDTH=4)
REQ-027 Reset: D=1010, S=011, EN=1, CR=1 for 2 edges -> Q=0000, QR=1111, SOR=0, SOL=0.
REQ-028 Load then right shift: load 1011, then S=001, DSR=0 for 3 edges -> Q = 0101, 0010, 0001; SOR = 1, 1, 0, 1 across the 4 edges.
REQ-029 Ring left: load 0001, then S=110 for 4 edges -> Q = 0010, 0100, 1000, 0001.
REQ-030 Johnson: from reset, S=101 for 8 edges -> Q = 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
REQ-031 Enable and priority:
- Q=1011, EN=0, S=001 for 3 edges -> Q stays 1011.
- Then CR=1 with EN=0 -> Q=0000.
REQ-032 Reset mid-operation and mode switch:
- Johnson from reset for 3 edges (Q=1110), then CR=1 for 1 edge -> Q=0000.
- Then S=010, DSL=1 for 2 edges -> Q = 0001, 0011.
